// File: rtl/ebi_write_fifo.sv
// EBI-attached write FIFO: the host writes bytes through an async EBI port,
// and a local consumer drains them through a show-ahead pop interface.
module ebi_write_fifo #(
    parameter int         DEPTH     = 8,
    parameter logic [2:0] ADDR_DATA = 3'b001,
    parameter logic [2:0] ADDR_STAT = 3'b010
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cs3,
    input  logic                     we,
    input  logic                     oe,
    input  logic [2:0]               address,
    inout  wire  [7:0]               data_bus,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STROBE  = 2'd1,
        WAIT_CS = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Two-flop synchronizers for the asynchronous EBI inputs
    // ------------------------------------------------------------------
    logic       cs_m_reg, cs_s_reg;
    logic       we_m_reg, we_s_reg;
    logic [2:0] addr_m_reg, addr_s_reg;
    logic [7:0] data_m_reg, data_s_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_m_reg   <= 1'b1;
            cs_s_reg   <= 1'b1;
            we_m_reg   <= 1'b1;
            we_s_reg   <= 1'b1;
            addr_m_reg <= 3'b000;
            addr_s_reg <= 3'b000;
        end else begin
            cs_m_reg   <= cs3;
            cs_s_reg   <= cs_m_reg;
            we_m_reg   <= we;
            we_s_reg   <= we_m_reg;
            addr_m_reg <= address;
            addr_s_reg <= addr_m_reg;
        end
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_data_sync
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data_m_reg[gi] <= 1'b0;
                data_s_reg[gi] <= 1'b0;
            end else begin
                data_m_reg[gi] <= data_bus[gi];
                data_s_reg[gi] <= data_m_reg[gi];
            end
        end
    end

    // ------------------------------------------------------------------
    // Write arming: the synchronizer reset values look like an idle bus,
    // so a strobe still held low across reset must be seen to end before
    // a new write may start.
    // ------------------------------------------------------------------
    logic [1:0] flush_cnt_reg;
    logic       armed_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt_reg <= 2'd0;
            armed_reg     <= 1'b0;
        end else begin
            if (flush_cnt_reg != 2'd2) begin
                flush_cnt_reg <= flush_cnt_reg + 2'd1;
            end
            if (flush_cnt_reg == 2'd2 && we_s_reg) begin
                armed_reg <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Write FSM
    // ------------------------------------------------------------------
    state_t state_reg, state_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (armed_reg && !cs_s_reg && !we_s_reg) begin
                    state_next = STROBE;
                end
            end
            STROBE: begin
                if (we_s_reg) begin
                    state_next = WAIT_CS;
                end else if (cs_s_reg) begin
                    state_next = IDLE;
                end
            end
            WAIT_CS: begin
                if (cs_s_reg) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    logic start_write;
    logic capture;
    logic commit;

    always_comb begin
        start_write = 1'b0;
        capture     = 1'b0;
        commit      = 1'b0;
        case (state_reg)
            IDLE: begin
                start_write = (state_next == STROBE);
                capture     = (state_next == STROBE);
            end
            STROBE: begin
                capture = !we_s_reg;
                commit  = we_s_reg;
            end
            default: ;
        endcase
    end

    // The commit pushes the byte captured while the strobe was still low,
    // since data_s may already be changing on the commit cycle.
    logic [2:0] addr_lat_reg;
    logic [7:0] wdata_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_lat_reg <= 3'b000;
            wdata_reg    <= 8'h00;
        end else begin
            if (start_write) begin
                addr_lat_reg <= addr_s_reg;
            end
            if (capture) begin
                wdata_reg <= data_s_reg;
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage and flags
    // ------------------------------------------------------------------
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg, count_next;
    logic          overflow_reg, overflow_next;

    logic commit_data;
    logic commit_stat;
    logic pop_ok;
    logic push_ok;
    logic drop;

    assign commit_data = commit && (addr_lat_reg == ADDR_DATA);
    assign commit_stat = commit && (addr_lat_reg == ADDR_STAT);
    assign pop_ok      = pop && valid;
    // A push into a full FIFO is still accepted when a pop frees a slot on the same edge.
    assign push_ok     = commit_data && (!full || pop_ok);
    assign drop        = commit_data && full && !pop_ok;

    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_comb begin
        overflow_next = overflow_reg;
        if (commit_stat) begin
            overflow_next = 1'b0;
        end else if (drop) begin
            overflow_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wdata_reg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
        end
    end

    assign count    = count_reg;
    assign valid    = (count_reg != '0);
    assign full     = (count_reg == DEPTH_C);
    assign overflow = overflow_reg;
    // Gate the head with valid so dout reads 0x00 while empty, including after reset.
    assign dout     = valid ? mem[rd_ptr_reg] : 8'h00;

    // ------------------------------------------------------------------
    // Read path: combinational from the raw pins
    // ------------------------------------------------------------------
    logic [7:0] status_byte;
    logic [7:0] rd_byte;
    logic       bus_drive;

    assign status_byte = {overflow_reg, full, ~valid, 1'b0, 4'(count_reg)};

    always_comb begin
        rd_byte   = 8'h00;
        bus_drive = 1'b0;
        if (!cs3 && !oe && we) begin
            if (address == ADDR_DATA) begin
                rd_byte   = dout;
                bus_drive = 1'b1;
            end else if (address == ADDR_STAT) begin
                rd_byte   = status_byte;
                bus_drive = 1'b1;
            end
        end
    end

    assign data_bus = bus_drive ? rd_byte : 8'hzz;

endmodule

// File: tb/tb_ebi_write_fifo.sv
// Randomized self-checking bench for ebi_write_fifo against a queue-based
// model of the FIFO, overflow flag and read-back bytes.
module tb_ebi_write_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cs3 = 1'b1;
    logic       we  = 1'b1;
    logic       oe  = 1'b1;
    logic [2:0] address = 3'b000;
    logic       pop = 1'b0;
    wire  [7:0] data_bus;
    logic [7:0] dout;
    logic       valid;
    logic       full;
    logic [3:0] count;
    logic       overflow;

    logic       drv_en   = 1'b0;
    logic [7:0] drv_data = 8'h00;

    assign data_bus = drv_en ? drv_data : 8'hzz;

    // Undriven bus reads back as 0xFF
    for (genvar gi = 0; gi < 8; gi++) begin : g_pu
        pullup pu_bit (data_bus[gi]);
    end

    always #5 clk = ~clk;

    ebi_write_fifo #(
        .DEPTH    (8),
        .ADDR_DATA(3'b001),
        .ADDR_STAT(3'b010)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cs3     (cs3),
        .we      (we),
        .oe      (oe),
        .address (address),
        .data_bus(data_bus),
        .pop     (pop),
        .dout    (dout),
        .valid   (valid),
        .full    (full),
        .count   (count),
        .overflow(overflow)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model
    logic [7:0] q[$];
    bit         m_ovf = 1'b0;

    function automatic logic [7:0] m_head();
        return (q.size() > 0) ? q[0] : 8'h00;
    endfunction

    function automatic logic [7:0] m_read(input logic [2:0] a);
        if (a == 3'b001) return m_head();
        if (a == 3'b010) return {m_ovf, q.size() == 8, q.size() == 0, 1'b0, 4'(q.size())};
        return 8'hFF;
    endfunction

    function automatic void m_write(input logic [2:0] a, input logic [7:0] d,
                                    input bit use_cs, input bit pop_commit);
        bit pop_ok;
        int pre;
        pre    = q.size();
        pop_ok = pop_commit && (pre > 0);
        if (pop_ok) void'(q.pop_front());
        if (use_cs && a == 3'b001) begin
            if (pre < 8 || pop_ok) q.push_back(d);
            else m_ovf = 1'b1;
        end else if (use_cs && a == 3'b010) begin
            m_ovf = 1'b0;
        end
    endfunction

    // Returns 4 clk edges after the we rising edge at the pin, cs3 still low.
    task automatic bus_write(input logic [2:0] a, input logic [7:0] d,
                             input bit use_cs, input bit pop_commit);
        @(negedge clk);
        cs3 = 1'b1; we = 1'b1; oe = 1'b1; drv_en = 1'b0; pop = 1'b0;
        repeat (4) @(negedge clk);
        address = a; drv_data = d; drv_en = 1'b1; cs3 = !use_cs;
        @(negedge clk);
        we = 1'b0;
        repeat (2) @(negedge clk);
        we = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        pop = pop_commit;
        @(posedge clk);
        @(negedge clk);
        pop = 1'b0;
        @(posedge clk);
        #1;
        m_write(a, d, use_cs, pop_commit);
        $display("write addr=%0d data=%02h cs=%0b pop=%0b -> count=%0d ovf=%0b",
                 a, d, use_cs, pop_commit, count, overflow);
    endtask

    task automatic bus_read(input logic [2:0] a, input logic oe_n, output logic [7:0] v);
        @(negedge clk);
        drv_en = 1'b0; we = 1'b1; address = a; cs3 = 1'b0; oe = oe_n;
        #2;
        v = data_bus;
        @(negedge clk);
        oe = 1'b1; cs3 = 1'b1;
        $display("read  addr=%0d oe=%0b -> %02h", a, oe_n, v);
    endtask

    task automatic do_pop();
        @(negedge clk);
        pop = 1'b1;
        @(negedge clk);
        pop = 1'b0;
        if (q.size() > 0) void'(q.pop_front());
        $display("pop   -> count=%0d dout=%02h", count, dout);
    endtask

    task automatic test_reset();
        logic [7:0] v;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        q.delete(); m_ovf = 1'b0;
        @(negedge clk);
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", valid); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %0b expected 0", full); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %0b expected 0", overflow); end
        n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %02h expected 00", dout); end
        bus_read(3'b010, 1'b0, v);
        n_checks++; if (v !== 8'h20) begin n_fail++; $display("FAIL reset_status: got %02h expected 20", v); end
    endtask

    task automatic test_out_of_range();
        bus_write(3'b000, 8'h96, 1'b1, 1'b0);
        n_checks++; if (count !== 4'(q.size())) begin n_fail++; $display("FAIL oor_count: got %0d expected %0d", count, q.size()); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL oor_valid: got %0b expected 0", valid); end
    endtask

    task automatic test_in_range();
        bus_write(3'b001, 8'h96, 1'b1, 1'b0);
        n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL inr_valid: got %0b expected 1", valid); end
        n_checks++; if (dout !== m_head()) begin n_fail++; $display("FAIL inr_dout: got %02h expected %02h", dout, m_head()); end
        n_checks++; if (count !== 4'(q.size())) begin n_fail++; $display("FAIL inr_count: got %0d expected %0d", count, q.size()); end
    endtask

    task automatic test_no_cs();
        bus_write(3'b001, 8'h5F, 1'b0, 1'b0);
        n_checks++; if (count !== 4'(q.size())) begin n_fail++; $display("FAIL nocs_count: got %0d expected %0d", count, q.size()); end
        n_checks++; if (dout !== m_head()) begin n_fail++; $display("FAIL nocs_dout: got %02h expected %02h", dout, m_head()); end
    endtask

    task automatic test_overflow();
        logic [7:0] v;
        for (int i = 0; q.size() < 8; i++) begin
            bus_write(3'b001, 8'h10 + 8'(i), 1'b1, 1'b0);
            n_checks++; if (count !== 4'(q.size())) begin n_fail++; $display("FAIL fill_count: got %0d expected %0d", count, q.size()); end
        end
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %0b expected 1", full); end
        bus_write(3'b001, 8'h5F, 1'b1, 1'b0);
        n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL ovf_count: got %0d expected 8", count); end
        n_checks++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL ovf_flag: got %0b expected %0b", overflow, m_ovf); end
        bus_read(3'b010, 1'b0, v);
        n_checks++; if (v !== m_read(3'b010)) begin n_fail++; $display("FAIL ovf_status: got %02h expected %02h", v, m_read(3'b010)); end
    endtask

    task automatic test_clear_and_drain();
        logic [7:0] v;
        bus_write(3'b010, 8'h00, 1'b1, 1'b0);
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL clr_overflow: got %0b expected 0", overflow); end
        // push and pop on the same edge while full
        bus_write(3'b001, 8'hE1, 1'b1, 1'b1);
        n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL fullpp_count: got %0d expected 8", count); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fullpp_overflow: got %0b expected 0", overflow); end
        n_checks++; if (dout !== m_head()) begin n_fail++; $display("FAIL fullpp_dout: got %02h expected %02h", dout, m_head()); end
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (dout !== m_head()) begin n_fail++; $display("FAIL drain_dout[%0d]: got %02h expected %02h", i, dout, m_head()); end
            do_pop();
            n_checks++; if (count !== 4'(q.size())) begin n_fail++; $display("FAIL drain_count[%0d]: got %0d expected %0d", i, count, q.size()); end
        end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid: got %0b expected 0", valid); end
        bus_read(3'b010, 1'b0, v);
        n_checks++; if (v !== 8'h20) begin n_fail++; $display("FAIL drain_status: got %02h expected 20", v); end
        do_pop();
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL empty_pop_count: got %0d expected 0", count); end
    endtask

    task automatic test_empty_push_pop();
        bus_write(3'b001, 8'h77, 1'b1, 1'b1);
        n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL emptypp_count: got %0d expected 1", count); end
        n_checks++; if (dout !== 8'h77) begin n_fail++; $display("FAIL emptypp_dout: got %02h expected 77", dout); end
    endtask

    task automatic test_read_oe();
        logic [7:0] v;
        bus_read(3'b001, 1'b0, v);
        n_checks++; if (v !== m_head()) begin n_fail++; $display("FAIL rd_data: got %02h expected %02h", v, m_head()); end
        bus_read(3'b000, 1'b0, v);
        n_checks++; if (v !== 8'hFF) begin n_fail++; $display("FAIL rd_oor_hiz: got %02h expected FF (released)", v); end
        bus_read(3'b001, 1'b1, v);
        n_checks++; if (v !== 8'hFF) begin n_fail++; $display("FAIL rd_oe_hiz: got %02h expected FF (released)", v); end
        n_checks++; if (count !== 4'(q.size())) begin n_fail++; $display("FAIL rd_nondestructive: got %0d expected %0d", count, q.size()); end
    endtask

    task automatic test_random();
        logic [7:0] v;
        logic [2:0] a;
        for (int i = 0; i < 50; i++) begin
            case ($urandom_range(0, 3))
                0, 1: begin
                    a = ($urandom_range(0, 7) < 5) ? 3'b001 : 3'($urandom_range(0, 7));
                    bus_write(a, 8'($urandom_range(0, 255)), $urandom_range(0, 7) != 0,
                              $urandom_range(0, 3) == 0);
                end
                2: do_pop();
                default: begin
                    a = 3'($urandom_range(0, 3));
                    bus_read(a, 1'b0, v);
                    n_checks++; if (v !== m_read(a)) begin n_fail++; $display("FAIL rnd_read[%0d]: addr %0d got %02h expected %02h", i, a, v, m_read(a)); end
                end
            endcase
            n_checks++; if (count !== 4'(q.size())) begin n_fail++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", i, count, q.size()); end
            n_checks++; if (dout !== m_head()) begin n_fail++; $display("FAIL rnd_dout[%0d]: got %02h expected %02h", i, dout, m_head()); end
            n_checks++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_overflow[%0d]: got %0b expected %0b", i, overflow, m_ovf); end
            n_checks++; if (full !== (q.size() == 8)) begin n_fail++; $display("FAIL rnd_full[%0d]: got %0b expected %0b", i, full, q.size() == 8); end
        end
    endtask

    task automatic test_mid_write_reset();
        @(negedge clk);
        cs3 = 1'b1; we = 1'b1; oe = 1'b1; drv_en = 1'b0;
        repeat (4) @(negedge clk);
        address = 3'b001; drv_data = 8'hA5; drv_en = 1'b1; cs3 = 1'b0;
        @(negedge clk);
        we = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        q.delete(); m_ovf = 1'b0;
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL mwr_count_release: got %0d expected 0", count); end
        repeat (4) @(negedge clk);
        we = 1'b1;
        repeat (6) @(negedge clk);
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL mwr_no_push: got %0d expected 0", count); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL mwr_valid: got %0b expected 0", valid); end
        $display("reset during write -> count=%0d", count);
        bus_write(3'b001, 8'h3C, 1'b1, 1'b0);
        n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL mwr_after_count: got %0d expected 1", count); end
        n_checks++; if (dout !== 8'h3C) begin n_fail++; $display("FAIL mwr_after_dout: got %02h expected 3C", dout); end
    endtask

    initial begin
        test_reset();
        test_out_of_range();
        test_in_range();
        test_no_cs();
        test_overflow();
        test_clear_and_drain();
        test_empty_push_pop();
        test_read_oe();
        test_random();
        test_mid_write_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ebi_write_fifo.md
EBI_WRITE_FIFO -- requirements
Module: ebi_write_fifo

Interface
REQ-001 Parameter: DEPTH, 8, FIFO depth in bytes (power of two).
REQ-002 Parameter: ADDR_DATA, 3'b001, EBIA[15:13] decode for the data port.
REQ-003 Parameter: ADDR_STAT, 3'b010, EBIA[15:13] decode for the status/control port.
REQ-004 Clocking: one clock; reset is asynchronous and active-high.
REQ-005 Ports (name, direction, width, meaning):
- clk, in, 1, system clock, rising edge.
- rst, in, 1, asynchronous active-high reset.
- cs3, in, 1, EBI chip select, active low.
- we, in, 1, EBI write strobe, active low.
- oe, in, 1, EBI output enable, active low.
- address, in, 3, EBIA[15:13].
- data_bus, inout, 8, EBI data.
- pop, in, 1, consumer dequeue request.
- dout, out, 8, head byte, show-ahead.
- valid, out, 1, FIFO not empty.
- full, out, 1, FIFO full.
- count, out, log2(DEPTH)+1, occupancy.
- overflow, out, 1, sticky dropped-write flag.

Function
REQ-006 Synchronizers: cs3, we, address and data_bus SHALL each pass through a 2-flop synchronizer before any sequential use; the resulting signals are cs_s, we_s, addr_s and data_s.
REQ-007 Write FSM: states IDLE, STROBE, WAIT_CS.
- IDLE -> STROBE when cs_s=0 and we_s=0; latch addr_s.
- STROBE: capture data_s every cycle.
- STROBE -> WAIT_CS when we_s=1, with commit in that cycle.
- STROBE -> IDLE without commit if cs_s=1 while we_s=0 (abort).
- WAIT_CS -> IDLE when cs_s=1.
REQ-008 Commit at ADDR_DATA: push the last captured byte if not full; if full, drop it and set overflow.
REQ-009 Commit at ADDR_STAT: clear overflow; the data value is ignored.
REQ-010 Commit at any other address: no effect.
REQ-011 A WE pulse with cs3 high SHALL never commit.
REQ-012 Push latency: the push or overflow update SHALL be visible on count, valid and overflow no later than 4 clk edges after the we rising edge at the pin.
REQ-013 Pop: pop=1 with valid=1 SHALL advance the head on that edge; pop with valid=0 SHALL be ignored.
REQ-014 Simultaneous push and pop when full: both occur; count unchanged; overflow not set.
REQ-015 Simultaneous push and pop when empty: pop ignored; push accepted.
REQ-016 Pointers: read and write pointers wrap modulo DEPTH.
REQ-017 Output flags: full=(count==DEPTH); valid=(count!=0).
REQ-018 Read path: data_bus SHALL be driven combinationally from raw pins only when cs3=0, oe=0 and we=1; otherwise it SHALL be high-Z.
REQ-019 Read at ADDR_DATA: drive dout; the read is non-destructive.
REQ-020 Read at ADDR_STAT: drive {overflow, full, ~valid, 1'b0, count[3:0]} (DEPTH=8).
REQ-021 Read at any other address: data_bus high-Z.

Reset
REQ-022 On rst: FIFO empty, pointers 0, count=0, valid=0, full=0, overflow=0, dout=0x00, FSM in IDLE.
REQ-023 Synchronizer reset values: cs/we/oe stages to 1, address and data stages to 0.
REQ-024 Reset during STROBE SHALL discard the pending write; the write SHALL NOT be committed after reset releases.

Verification
REQ-025 Out-of-range write: cs3=0, address=000, write 0x96 -> count=0, valid=0.
REQ-026 In-range write: cs3=0, address=001, WE low 2 cycles, data 0x96 -> within 4 edges valid=1, dout=0x96, count=1.
REQ-027 Write without chip select: address=001, WE pulse carrying 0x5F, cs3=1 -> count unchanged.
REQ-028 Overflow: fill with 8 bytes, then write 0x5F -> byte dropped; status read at ADDR_STAT returns 0xC8.
REQ-029 Overflow clear: write 0x00 to ADDR_STAT -> overflow=0. Then pop 8 times -> bytes emerge in order; valid=0, status read = 0x20.
REQ-030 Read with oe: oe=0, cs3=0, address=001 -> data_bus=dout. Then address=000 -> data_bus high-Z.
REQ-031 Mid-write reset: rst pulsed while WE low at ADDR_DATA -> after release count=0 and no push occurs.
